// File: rtl/adder32_share_pkg.sv
// Shared types for the adder-sharing arbiter: FSM state encoding and
// operand/result widths of the 32-bit carry-lookahead core.
package adder32_share_pkg;
  localparam int ADD_W = 32;
  localparam int SUM_W = 33;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  typedef logic [ADD_W-1:0] operand_t;
  typedef logic [SUM_W-1:0] sum_t;
endpackage

// File: rtl/adder32_cla.sv
// 32-bit carry-lookahead adder core (purely combinational).
// Ports: add1_i, add2_i - 32-bit unsigned operands
//        result_o       - 33-bit sum, bit 32 = carry out
// 4-bit lookahead groups; group carries chained through group G/P terms.
module adder32_cla (
  input  logic [31:0] add1_i,
  input  logic [31:0] add2_i,
  output logic [32:0] result_o
);
  logic [31:0] p, g, c;
  logic [8:0]  gc;

  assign p     = add1_i ^ add2_i;
  assign g     = add1_i & add2_i;
  assign gc[0] = 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] pk, gk;
    logic       grp_g, grp_p;
    assign pk = p[4*k +: 4];
    assign gk = g[4*k +: 4];
    assign grp_g = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) |
                   (pk[3] & pk[2] & pk[1] & gk[0]);
    assign grp_p = &pk;
    assign gc[k+1] = grp_g | (grp_p & gc[k]);
    // bit carries inside the group, all expanded from the group carry-in
    assign c[4*k]   = gc[k];
    assign c[4*k+1] = gk[0] | (pk[0] & gc[k]);
    assign c[4*k+2] = gk[1] | (pk[1] & gk[0]) | (pk[1] & pk[0] & gc[k]);
    assign c[4*k+3] = gk[2] | (pk[2] & gk[1]) | (pk[2] & pk[1] & gk[0]) |
                      (pk[2] & pk[1] & pk[0] & gc[k]);
  end

  assign result_o = {gc[8], p ^ c};
endmodule

// File: rtl/adder32_rr_arb.sv
// Grant logic for the shared adder. One-hot grant over req_i.
// Macro ADD_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins, ptr_i
// ignored). Default: round robin, search starts at ptr_i and wraps.
// Ports: req_i    - request vector
//        ptr_i    - round-robin start index (< NUM_REQ)
//        gnt_o    - one-hot grant, zero when no request
//        gnt_id_o - index of granted requester
//        any_o    - a grant was issued
module adder32_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o,
  output logic               any_o
);
`ifdef ADD_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_o && req_i[i]) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        gnt_id_o = ID_W'(i);
      end
    end
  end
`else
  always_comb begin
    int idx;
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end
`endif
endmodule

// File: rtl/adder32_share_arbiter.sv
// Shares one 32-bit CLA adder between NUM_REQ valid/ready requesters.
// Flow IDLE (grant, latch operands) -> CALC (register core result) ->
// RESP (hold result until rsp_ready_i).
// Ports: clk_i, rst_ni (sync, active low)
//        req_valid_i/req_ready_o/req_a_i/req_b_i - requester side, 32b lanes
//        rsp_valid_o/rsp_ready_i/rsp_sum_o/rsp_id_o - response side
//        busy_o - not IDLE; ops_cnt_o - completed response handshakes
// Macro ADD_ARB_FIXED_PRIO_EN (in adder32_rr_arb) selects fixed priority.
module adder32_share_arbiter
  import adder32_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*ADD_W-1:0] req_a_i,
  input  logic [NUM_REQ*ADD_W-1:0] req_b_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [SUM_W-1:0]         rsp_sum_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         ops_cnt_o
);
  state_e            state_q, state_d;
  operand_t          a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d, rr_q, rr_d, rsp_id_q, rsp_id_d;
  sum_t              sum_q, sum_d, core_sum;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt, ready;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;

  adder32_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i    (req_valid_i),
    .ptr_i    (rr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  // core sees only the operand registers, never the live request lanes
  adder32_cla u_core (
    .add1_i   (a_q),
    .add2_i   (b_q),
    .result_o (core_sum)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rr_d        = rr_q;
    sum_d       = sum_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    ready       = '0;
    case (state_q)
      IDLE: begin
        ready = gnt;
        // grant is a subset of valid, so any grant is a handshake
        if (gnt_any) begin
          a_d     = req_a_i[ADD_W*int'(gnt_id) +: ADD_W];
          b_d     = req_b_i[ADD_W*int'(gnt_id) +: ADD_W];
          id_d    = gnt_id;
          rr_d    = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d       = core_sum;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rr_q        <= '0;
      sum_q       <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      sum_q       <= sum_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // handshake outputs are forced quiet while reset is asserted
  assign req_ready_o = rst_ni ? ready : '0;
  assign busy_o      = rst_ni && (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = sum_q;
  assign rsp_id_o    = rsp_id_q;
  assign ops_cnt_o   = cnt_q;
endmodule

// File: tb/tb_adder32_share_arbiter.sv
module tb_adder32_share_arbiter;
  localparam int NR = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [NR-1:0]   req_valid_i, req_ready_o;
  logic [NR*32-1:0] req_a_i, req_b_i;
  logic            rsp_valid_o, rsp_ready_i, busy_o;
  logic [32:0]     rsp_sum_o;
  logic [1:0]      rsp_id_o;
  logic [15:0]     ops_cnt_o;

  adder32_share_arbiter #(.NUM_REQ(NR), .ID_W(2), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o), .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_sum_o(rsp_sum_o), .rsp_id_o(rsp_id_o), .busy_o(busy_o),
    .ops_cnt_o(ops_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0;
  int model_ptr = 0;
  int exp_cnt = 0;
  logic [31:0] lane_a [NR];
  logic [31:0] lane_b [NR];

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    bit          early;
    int          exp_id;
    logic [32:0] exp_sum;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < NR; i++) begin
      req_a_i[32*i +: 32] = lane_a[i];
      req_b_i[32*i +: 32] = lane_b[i];
    end
  endtask

  // spec rule: first valid requester at or after the pointer, wrapping
  function automatic int model_grant(input logic [3:0] mask, input int ptr);
`ifdef ADD_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NR; k++) if (mask[k]) return k;
`else
    for (int k = 0; k < NR; k++) if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
`endif
    return -1;
  endfunction

  // one request phase; when granted, follows the op through to handshake
  task automatic run_op(input logic [3:0] mask, input int hold, input bit early,
                        input int exp_id, input logic [32:0] exp_sum);
    req_valid_i = mask;
    pack();
    rsp_ready_i = early;
    #1;
    chk("grant", {60'd0, req_ready_o}, (exp_id < 0) ? 64'd0 : (64'd1 << exp_id));
    chk("busy_idle", {63'd0, busy_o}, 64'd0);
    if (exp_id < 0) begin
      tick();
      req_valid_i = '0;
      return;
    end
    tick();
    // scramble lanes after accept: the registered operands must be used
    for (int i = 0; i < NR; i++) begin
      lane_a[i] = $urandom;
      lane_b[i] = $urandom;
    end
    pack();
    rsp_ready_i = (hold == 0);
    #1;
    chk("calc_ready", {60'd0, req_ready_o}, 64'd0);
    chk("calc_busy", {63'd0, busy_o}, 64'd1);
    chk("calc_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    tick();
    chk("rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
    chk("rsp_sum", {31'd0, rsp_sum_o}, {31'd0, exp_sum});
    chk("rsp_id", {62'd0, rsp_id_o}, 64'(exp_id));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", {63'd0, rsp_valid_o}, 64'd1);
      chk("hold_sum", {31'd0, rsp_sum_o}, {31'd0, exp_sum});
      chk("hold_id", {62'd0, rsp_id_o}, 64'(exp_id));
      chk("hold_ready", {60'd0, req_ready_o}, 64'd0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    req_valid_i = '0;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("done_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("ops_cnt", {48'd0, ops_cnt_o}, 64'(exp_cnt));
    chk("done_busy", {63'd0, busy_o}, 64'd0);
    model_ptr = (exp_id + 1) % NR;
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{4'b0100, 32'h0000_0005, 32'h0000_0007, 0, 1'b1, 2, 33'h0_0000_000C};
    vecs[1] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0, 0, 33'h1_0000_0000};
    vecs[2] = '{4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0, 1, 33'h1_FFFF_FFFE};
    vecs[3] = '{4'b1111, 32'h0000_0000, 32'h0000_0000, 0, 1'b1, 2, 33'h0_0000_0000};
    vecs[4] = '{4'b1111, 32'h1234_5678, 32'h8765_4321, 10, 1'b0, 3, 33'h0_9999_9999};
    vecs[5] = '{4'b1111, 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 0, 33'h1_0000_0000};
    vecs[6] = '{4'b1111, 32'h7FFF_FFFF, 32'h0000_0001, 2, 1'b0, 1, 33'h0_8000_0000};
    vecs[7] = '{4'b0000, 32'h0000_0001, 32'h0000_0001, 0, 1'b1, -1, 33'h0};

    // reset with every requester asking
    rst_ni = 1'b0;
    req_valid_i = '1;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < NR; i++) begin lane_a[i] = 32'd1; lane_b[i] = 32'd1; end
    pack();
    tick();
    tick();
    chk("rst_ready", {60'd0, req_ready_o}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("rst_cnt", {48'd0, ops_cnt_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_sum", {31'd0, rsp_sum_o}, 64'd0);
    chk("rst_id", {62'd0, rsp_id_o}, 64'd0);
    req_valid_i = '0;
    rst_ni = 1'b1;
    tick();

    // directed table (round-robin ids from pointer 0)
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NR; i++) begin lane_a[i] = vecs[v].a; lane_b[i] = vecs[v].b; end
      run_op(vecs[v].mask, vecs[v].hold, vecs[v].early, vecs[v].exp_id, vecs[v].exp_sum);
    end

    // reset while in CALC: op dropped, counter and pointer cleared
    lane_a[1] = 32'd10; lane_b[1] = 32'd20; pack();
    req_valid_i = 4'b0010;
    tick();
    req_valid_i = '0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready", {60'd0, req_ready_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, rsp_valid_o}, 64'd0);
    chk("mid_rst_cnt", {48'd0, ops_cnt_o}, 64'd0);
    chk("mid_rst_busy2", {63'd0, busy_o}, 64'd0);
    tick();
    tick();
    chk("mid_rst_no_rsp", {63'd0, rsp_valid_o}, 64'd0);
    exp_cnt = 0;
    model_ptr = 0;

    // all four valid continuously: order 0,1,2,3,0
    begin
      int rr_ids [5];
      rr_ids = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < NR; i++) begin lane_a[i] = 32'(i * 100 + k); lane_b[i] = 32'(i); end
        run_op(4'b1111, 0, 1'b1, rr_ids[k], 33'(rr_ids[k] * 101 + k));
      end
    end

    // randomized against the reference model
    for (int r = 0; r < 60; r++) begin
      logic [3:0] mask;
      int id;
      logic [32:0] es;
      mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        lane_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        lane_b[i] = $urandom;
      end
      id = model_grant(mask, model_ptr);
      es = (id < 0) ? 33'd0 : ({1'b0, lane_a[id]} + {1'b0, lane_b[id]});
      run_op(mask, $urandom_range(0, 3), 1'($urandom_range(0, 1)), id, es);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
